dcache_ctrl: RTL
================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back data cache controller for the MEM stage.
- Each line is one 64-bit word held in a data bank. The block keeps the tag, valid and dirty arrays and sequences hit, miss, writeback and refill.
- Bridges a CPU-side valid/ready request port to a simple single-beat memory port.

Parameters:
- SETS, 64, number of lines; power of two, at least 2.
- IDX_W, 6, log2(SETS).
- ADDR_W, 64, address width; byte address, bits [2:0] select the byte in the word.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  64  store data.
- req_wstrb  in  8  store byte enables.
- rsp_valid  out  1  one-cycle pulse: load data valid or store complete.
- rsp_rdata  out  64  load data; 0 for stores.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = writeback, 0 = refill read.
- mem_addr  out  ADDR_W  word-aligned address; bits [2:0] = 0.
- mem_wdata  out  64  victim data.
- mem_ack  in  1  one-cycle completion from memory.
- mem_rdata  in  64  refill data, valid with mem_ack.

Behaviour:
- Address split: offset [2:0], index [IDX_W+2:3], tag [ADDR_W-1:IDX_W+3].
- Reset (async, rst=1):
  - state=IDLE; all valid and dirty bits cleared.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Data contents are undefined after reset.
  - Reset mid-transaction aborts it: mem_req drops in the same cycle, and no rsp_valid is issued.
- States: IDLE, LOOKUP, WB, REFILL, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/addr/wdata/wstrb, read tag/valid/dirty/data at the index, and go to LOOKUP.
  - req_ready=0 in every other state.
- LOOKUP:
  - Hit = valid & tag match.
  - Hit load: rsp_rdata = data, rsp_valid=1 this cycle, next state IDLE. Load-hit latency is 1 cycle after acceptance.
  - Hit store: merge wdata into the line by wstrb, set dirty, rsp_valid=1, next state IDLE.
  - Miss with valid & dirty victim: go to WB with mem_addr = {victim_tag, index, 3'b0} and mem_wdata = victim data.
  - Miss otherwise: go to REFILL with mem_addr = {req_tag, index, 3'b0}.
- WB:
  - mem_req=1, mem_we=1.
  - On mem_ack, go to REFILL; mem_addr switches to the request line.
- REFILL:
  - mem_req=1, mem_we=0.
  - On mem_ack, write the line with mem_rdata; set tag and valid.
  - Load: dirty=0. Store: merge wdata by wstrb into mem_rdata before writing, dirty=1.
  - Next state RESP.
- RESP:
  - rsp_valid=1, with rsp_rdata = refilled word for loads and 0 for stores.
  - Next state IDLE.
- mem_req may go active only in WB or REFILL. It stays stable with stable address and data until mem_ack.
- mem_ack outside WB/REFILL is ignored.
- rsp_valid is never high for two consecutive cycles; back-to-back hits therefore give one response every 2 cycles.
- Aliasing: a new request in IDLE always sees updates from the previous completed request.
- wstrb=0 store: behaves as a store (dirty set) with no data change.

Optional Feature:
- Macro: DCACHE_PERF_EN.
- Defined:
  - Adds outputs perf_hit and perf_miss, each 32-bit, reset to 0.
  - perf_hit increments on each LOOKUP hit; perf_miss on each LOOKUP miss.
  - Counters wrap at 2^32 to 0.
- Undefined: no ports and no counter logic; behaviour is otherwise identical.

Decomposition:
- defines.v holds:
  - state encoding constants DC_IDLE=0, DC_LOOKUP=1, DC_WB=2, DC_REFILL=3, DC_RESP=4 (3 bits);
  - the DC_OFF_W=3 constant;
  - a strobe-merge function (64-bit old, 64-bit new, 8-bit strobe).
- Sub-module dcache_meta: SETS-entry tag/valid/dirty array, registered read, synchronous write, asynchronous clear on rst.
- The data array is a SETS-deep generalization of the one-word data bank. It stays inside dcache_ctrl as a reg array.

Test Plan:
- Cold load miss to addr 0x80000010:
  - Expect REFILL with mem_addr=0x80000010, mem_we=0.
  - Ack with rdata 0x1122334455667788; rsp_valid in the cycle after ack with that data.
  - Repeat the same load: hit, with rsp_valid 1 cycle after acceptance and no mem_req.
- Store hit to 0x80000010, wdata 0xAAAAAAAAAAAAAAAA, wstrb 0x0F, then load it: expect 0x11223344AAAAAAAA.
- Dirty eviction: store to 0x80000010, then load 0x80000210 (SETS=64, same index):
  - Expect WB with mem_addr=0x80000010, mem_we=1 and the dirty data.
  - Then REFILL with mem_addr=0x80000210.
- Store miss to a clean line, wstrb 0xF0, wdata 0xBBBB...BB, refill 0x0: line becomes 0xBBBBBBBB00000000 and dirty; rsp_rdata=0.
- Hold mem_ack low for 10 cycles during REFILL: mem_req/mem_addr stable, req_ready=0. Then assert rst mid-REFILL: mem_req=0 immediately, all lines invalid, and the next load misses.
- With DCACHE_PERF_EN: 3 misses and 5 hits give perf_miss=3, perf_hit=5; rst clears both.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// Shared types and helpers for the direct-mapped write-back data cache controller.
// State encoding, byte-offset width and the store strobe-merge function.
package dcache_ctrl_pkg;

    typedef enum logic [2:0] {
        DC_IDLE   = 3'd0,
        DC_LOOKUP = 3'd1,
        DC_WB     = 3'd2,
        DC_REFILL = 3'd3,
        DC_RESP   = 3'd4
    } dc_state_t;

    localparam int unsigned DC_OFF_W = 3;

    function automatic logic [63:0] strb_merge(
        input logic [63:0] old_word,
        input logic [63:0] new_word,
        input logic [7:0]  strb
    );
        logic [63:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < 8; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_meta.sv
// Tag/valid/dirty array for the data cache: registered read, synchronous write,
// valid and dirty bits cleared asynchronously on rst.
module dcache_meta #(
    parameter int unsigned SETS  = 64,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned TAG_W = 55
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    output logic             rd_dirty,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             wr_dirty
);

    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_mem [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= '0;
            dirty_q  <= '0;
            rd_valid <= 1'b0;
            rd_dirty <= 1'b0;
        end else begin
            if (wr_en) begin
                valid_q[wr_idx] <= 1'b1;
                dirty_q[wr_idx] <= wr_dirty;
            end
            if (rd_en) begin
                rd_valid <= valid_q[rd_idx];
                rd_dirty <= dirty_q[rd_idx];
            end
        end
    end

    // Tags need no reset: a cleared valid bit masks whatever they hold.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
        end
        if (rd_en) begin
            rd_tag <= tag_mem[rd_idx];
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller, one 64-bit word per line.
// Optional hit/miss counters are enabled by defining DCACHE_PERF_EN.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int unsigned SETS   = 64,
    parameter int unsigned IDX_W  = 6,
    parameter int unsigned ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_wstrb,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata
`ifdef DCACHE_PERF_EN
    ,
    output logic [31:0]       perf_hit,
    output logic [31:0]       perf_miss
`endif
);

    localparam int unsigned TAG_W  = ADDR_W - IDX_W - DC_OFF_W;
    localparam int unsigned LINE_W = ADDR_W - DC_OFF_W;
    localparam logic [DC_OFF_W-1:0] OFF_ZERO = '0;

    dc_state_t         state_q, state_d;
    logic              r_we;
    logic [LINE_W-1:0] r_line;
    logic [63:0]       r_wdata;
    logic [7:0]        r_wstrb;
    logic [63:0]       rd_data;
    logic [63:0]       data_mem [SETS];
    logic [IDX_W-1:0]  r_idx, req_idx;
    logic [TAG_W-1:0]  r_tag, m_tag;
    logic              m_valid, m_dirty;
    logic              accept, hit, line_we;
    logic [63:0]       line_new;
    logic              unused_off;

    assign req_idx    = req_addr[IDX_W+DC_OFF_W-1:DC_OFF_W];
    assign r_idx      = r_line[IDX_W-1:0];
    assign r_tag      = r_line[LINE_W-1:IDX_W];
    assign accept     = (state_q == DC_IDLE) && req_valid;
    assign hit        = m_valid && (m_tag == r_tag);
    assign unused_off = ^req_addr[DC_OFF_W-1:0];

    dcache_meta #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_meta (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (accept),
        .rd_idx   (req_idx),
        .rd_tag   (m_tag),
        .rd_valid (m_valid),
        .rd_dirty (m_dirty),
        .wr_en    (line_we),
        .wr_idx   (r_idx),
        .wr_tag   (r_tag),
        .wr_dirty (r_we)
    );

    // Store hits and refills share one write port; dirty simply follows r_we.
    always_comb begin
        line_we  = 1'b0;
        line_new = strb_merge(rd_data, r_wdata, r_wstrb);
        if (state_q == DC_LOOKUP && hit && r_we) begin
            line_we = 1'b1;
        end
        if (state_q == DC_REFILL && mem_ack) begin
            line_we  = 1'b1;
            line_new = r_we ? strb_merge(mem_rdata, r_wdata, r_wstrb) : mem_rdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            DC_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = DC_LOOKUP;
                end
            end
            DC_LOOKUP: begin
                if (hit) begin
                    rsp_valid = 1'b1;
                    state_d   = DC_IDLE;
                end else if (m_valid && m_dirty) begin
                    state_d = DC_WB;
                end else begin
                    state_d = DC_REFILL;
                end
            end
            DC_WB: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    state_d = DC_REFILL;
                end
            end
            DC_REFILL: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = DC_RESP;
                end
            end
            DC_RESP: begin
                rsp_valid = 1'b1;
                state_d   = DC_IDLE;
            end
            default: state_d = DC_IDLE;
        endcase
        rsp_rdata = (rsp_valid && !r_we) ? rd_data : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DC_IDLE;
            r_we      <= 1'b0;
            r_line    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            rd_data   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                r_we    <= req_we;
                r_line  <= req_addr[ADDR_W-1:DC_OFF_W];
                r_wdata <= req_wdata;
                r_wstrb <= req_wstrb;
                rd_data <= data_mem[req_idx];
            end
            if (state_q == DC_LOOKUP && !hit) begin
                if (m_valid && m_dirty) begin
                    mem_addr  <= {m_tag, r_idx, OFF_ZERO};
                    mem_wdata <= rd_data;
                end else begin
                    mem_addr <= {r_tag, r_idx, OFF_ZERO};
                end
            end
            if (state_q == DC_WB && mem_ack) begin
                mem_addr <= {r_tag, r_idx, OFF_ZERO};
            end
            // Keep the refilled word for the RESP-cycle load data.
            if (state_q == DC_REFILL && mem_ack) begin
                rd_data <= line_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            data_mem[r_idx] <= line_new;
        end
    end

`ifdef DCACHE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hit  <= '0;
            perf_miss <= '0;
        end else if (state_q == DC_LOOKUP) begin
            if (hit) begin
                perf_hit <= perf_hit + 32'd1;
            end else begin
                perf_miss <= perf_miss + 32'd1;
            end
        end
    end
`endif

endmodule
